// File: rtl/serial_subtract_ctrl_pkg.sv
// serial_subtract_ctrl_pkg: state encodings shared by the serial subtractor and its bench
// Binary encoding: IDLE=0, RUN=1, DONE=2.
package serial_subtract_ctrl_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/serial_subtract_ctrl_subtract_1_bit.sv
// subtract_1_bit: 1-bit full subtractor computing x - y - bin
// Ports: x minuend bit, y subtrahend bit, bin borrow in; d difference bit, bout borrow out.
module subtract_1_bit (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);
    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);
endmodule

// File: rtl/serial_subtract_ctrl.sv
// serial_subtract_ctrl: bit-serial a - b - bin, LSB first, one bit per clock
// Ports: clk, rst_n (async active-low); start/a/b/bin request an operation while idle;
// busy high in RUN and DONE; done pulses one cycle with diff/bout/ovf valid, held until the next result.
module serial_subtract_ctrl
    import serial_subtract_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    state_t           state, nxt;
    logic [WIDTH-1:0] a_sh, b_sh, res_n;
    logic [WIDTH-2:0] res;
    logic [CW-1:0]    cnt;
    logic             brw, a_msb, b_msb, d_bit, b_out, last;
    subtract_1_bit u_sub (
        .x    (a_sh[0]),
        .y    (b_sh[0]),
        .bin  (brw),
        .d    (d_bit),
        .bout (b_out)
    );
    // res holds the bits produced so far; res_n is the word including this cycle's bit
    assign res_n = {d_bit, res};
    assign last  = cnt == CW'(WIDTH - 1);
    assign busy  = state != IDLE;
    assign done  = state == DONE;
    always_comb begin
        nxt = state == IDLE ? (start ? RUN : IDLE) :
              state == RUN  ? (last ? DONE : RUN) : IDLE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            brw   <= 1'b0;
            a_sh  <= '0;
            b_sh  <= '0;
            res   <= '0;
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            diff  <= '0;
            bout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            state <= nxt;
            if (state == IDLE && start) begin
                a_sh  <= a;
                b_sh  <= b;
                brw   <= bin;
                a_msb <= a[WIDTH-1];
                b_msb <= b[WIDTH-1];
                cnt   <= '0;
            end else if (state == RUN) begin
                a_sh <= a_sh >> 1;
                b_sh <= b_sh >> 1;
                res  <= res_n[WIDTH-1:1];
                brw  <= b_out;
                cnt  <= last ? cnt : cnt + 1'b1;
                // outputs change only once the final bit is known, so no partial result is ever visible
                if (last) begin
                    diff <= res_n;
                    bout <= b_out;
                    ovf  <= (a_msb ^ b_msb) & (d_bit ^ a_msb);
                end
            end
        end
    end
endmodule
